// File: rtl/param_fifo_if.sv
// Handshake/data bundle between a producer/consumer and param_fifo.
// Ports: push/pop/flush/clear_err/data_in are driven by the user (master);
//        data_out, count, status and error flags are driven by the FIFO (slave).
interface param_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic             flush;
  logic             clear_err;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, flush, clear_err, data_in,
    input  data_out, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  push, pop, flush, clear_err, data_in,
    output data_out, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty, sticky overflow/underflow and synchronous flush.
// Ports: clk, reset_n (asynchronous, active-high), bus (param_fifo_if.slave).
// Macro FIFO_FWFT_EN: when defined, first-word-fall-through output (head of
// queue shown combinationally); otherwise data_out is registered on each
// accepted pop (one cycle read latency).
module param_fifo #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  param_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;

  logic full_w;
  logic empty_w;
  logic pop_acc;
  logic push_acc;
  logic push_rej;
  logic pop_rej;

  // Status flags decode the registered count only, so they change just
  // after a clock edge and never glitch on input activity.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // Flush overrides both requests: nothing is accepted or rejected that cycle.
  assign pop_acc  = bus.pop && !empty_w && !bus.flush;
  // A push into a full FIFO is fine when a pop frees the slot on the same edge.
  assign push_acc = bus.push && (!full_w || pop_acc) && !bus.flush;
  assign push_rej = bus.push && !bus.flush && !push_acc;
  assign pop_rej  = bus.pop  && !bus.flush && empty_w;

  // Pointers and occupancy. DEPTH is a power of two, so the natural
  // pointer roll-over gives the modulo-DEPTH wrap with no gap.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only slots below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= bus.data_in;
  end

  // Sticky error flags. A fresh error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clear_err) begin
      overflow_q  <= push_rej;
      underflow_q <= pop_rej;
    end else begin
      if (push_rej) overflow_q  <= 1'b1;
      if (pop_rej)  underflow_q <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // hold_q tracks the word currently presented so that, once the FIFO
  // drains or is flushed, data_out keeps showing the last head entry.
  logic [WIDTH-1:0] hold_q;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      hold_q <= '0;
    end else if (!empty_w) begin
      hold_q <= mem[rd_ptr];
    end
  end

  assign bus.data_out = empty_w ? hold_q : mem[rd_ptr];
`else
  // Registered read: loaded only on an accepted pop, held otherwise.
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      dout_q <= '0;
    end else if (pop_acc) begin
      dout_q <= mem[rd_ptr];
    end
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (default or FIFO_FWFT_EN build).
// A queue-based reference model tracks expected contents, data_out and flags.
module tb_param_fifo;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;
  localparam int CW = $clog2(D) + 1;
  localparam int VW = W + CW + 6;
`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  param_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  param_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_ovf;
  logic         m_udf;

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_edge(input bit p, input bit po, input bit f, input bit ce,
                            input logic [W-1:0] d);
    bit pop_ok, push_ok, ov, ud;
    logic [W-1:0] head;
    ov = 1'b0;
    ud = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      pop_ok  = po && (q.size() > 0);
      push_ok = p && ((q.size() < D) || pop_ok);
      ov = p && !push_ok;
      ud = po && !pop_ok;
      if (pop_ok) begin
        head = q.pop_front();
        if (!FWFT) m_dout = head;
      end
      if (push_ok) q.push_back(d);
    end
    m_ovf = ce ? ov : (m_ovf | ov);
    m_udf = ce ? ud : (m_udf | ud);
    if (FWFT && q.size() > 0) m_dout = q[0];
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {bus.data_out, bus.count, bus.full, bus.empty, bus.almost_full,
            bus.almost_empty, bus.overflow, bus.underflow};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    int n;
    n = q.size();
    return {m_dout, CW'(n), (n == D), (n == 0), (n >= AF), (n <= AE), m_ovf, m_udf};
  endfunction

  // One clock: apply inputs, take the edge, advance the model, idle inputs.
  task automatic cyc(input bit p, input bit po, input bit f, input bit ce,
                     input logic [W-1:0] d);
    bus.push = p; bus.pop = po; bus.flush = f; bus.clear_err = ce; bus.data_in = d;
    @(posedge clk);
    #1;
    model_edge(p, po, f, ce, d);
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clear_err = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clear_err = 1'b0;
    bus.data_in = '0;
    model_reset();
    #12;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), exp_vec());
    end
    checks++;
    if (bus.count !== CW'(0) || bus.empty !== 1'b1 || bus.almost_empty !== 1'b1
        || bus.data_out !== W'(0)) begin
      failures++;
      $display("FAIL reset_values count=%0d empty=%b ae=%b dout=%h exp 0/1/1/0",
               bus.count, bus.empty, bus.almost_empty, bus.data_out);
    end
    reset_n = 1'b0;
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] e;
    for (int i = 0; i < D; i++) begin
      cyc(1, 0, 0, 0, (i % 2 == 0) ? 16'hFFFF : 16'h0000);
      checks++;
      if (bus.count !== CW'(i + 1) || bus.almost_full !== (i + 1 >= 6)
          || bus.almost_empty !== (i + 1 <= 2) || bus.full !== (i + 1 == 8)) begin
        failures++;
        $display("FAIL fill[%0d] count=%0d af=%b ae=%b full=%b", i, bus.count,
                 bus.almost_full, bus.almost_empty, bus.full);
      end
    end
    cyc(1, 0, 0, 0, 16'hAAAA);
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== CW'(8) || bus.full !== 1'b1) begin
      failures++;
      $display("FAIL overflow_push ovf=%b count=%0d exp ovf=1 count=8", bus.overflow, bus.count);
    end
    for (int i = 0; i < D; i++) begin
      e = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
`ifdef FIFO_FWFT_EN
      checks++;
      if (bus.data_out !== e) begin
        failures++;
        $display("FAIL drain[%0d] got=%h exp=%h", i, bus.data_out, e);
      end
      cyc(0, 1, 0, 0, '0);
`else
      cyc(0, 1, 0, 0, '0);
      checks++;
      if (bus.data_out !== e) begin
        failures++;
        $display("FAIL drain[%0d] got=%h exp=%h", i, bus.data_out, e);
      end
`endif
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL drain_state[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL drain_empty got=%b exp=1", bus.empty);
    end
  endtask

  task automatic test_underflow();
    logic [W-1:0] held;
    held = m_dout;
    cyc(0, 1, 0, 0, '0);
    checks++;
    if (bus.underflow !== 1'b1 || bus.data_out !== held) begin
      failures++;
      $display("FAIL underflow udf=%b dout=%h exp udf=1 dout=%h", bus.underflow, bus.data_out, held);
    end
    cyc(0, 0, 0, 1, '0);
    checks++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_err ovf=%b udf=%b exp 0/0", bus.overflow, bus.underflow);
    end
    cyc(0, 1, 0, 1, '0);
    checks++;
    if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_vs_error udf=%b ovf=%b exp 1/0", bus.underflow, bus.overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] w [D];
    logic [W-1:0] e;
    cyc(0, 0, 0, 1, '0);
    for (int i = 0; i < D; i++) begin
      w[i] = W'($urandom);
      cyc(1, 0, 0, 0, w[i]);
    end
    cyc(1, 1, 0, 0, 16'h1234);
    checks++;
    if (bus.count !== CW'(8) || bus.overflow !== 1'b0 || bus.full !== 1'b1) begin
      failures++;
      $display("FAIL full_push_pop count=%0d ovf=%b exp count=8 ovf=0", bus.count, bus.overflow);
    end
    for (int i = 0; i < D; i++) begin
      e = (i < D - 1) ? w[i + 1] : 16'h1234;
`ifdef FIFO_FWFT_EN
      checks++;
      if (bus.data_out !== e) begin
        failures++;
        $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, bus.data_out, e);
      end
      cyc(0, 1, 0, 0, '0);
`else
      cyc(0, 1, 0, 0, '0);
      checks++;
      if (bus.data_out !== e) begin
        failures++;
        $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, bus.data_out, e);
      end
`endif
    end
  endtask

  task automatic test_wrap();
    int in_idx;
    int out_idx;
    in_idx = 0;
    out_idx = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, W'(in_idx));
      in_idx++;
    end
    for (int r = 0; r < 25; r++) begin
`ifdef FIFO_FWFT_EN
      checks++;
      if (bus.data_out !== W'(out_idx)) begin
        failures++;
        $display("FAIL wrap[%0d] got=%h exp=%h", r, bus.data_out, W'(out_idx));
      end
      if (r < 20) cyc(1, 1, 0, 0, W'(in_idx)); else cyc(0, 1, 0, 0, '0);
`else
      if (r < 20) cyc(1, 1, 0, 0, W'(in_idx)); else cyc(0, 1, 0, 0, '0);
      checks++;
      if (bus.data_out !== W'(out_idx)) begin
        failures++;
        $display("FAIL wrap[%0d] got=%h exp=%h", r, bus.data_out, W'(out_idx));
      end
`endif
      if (r < 20) in_idx++;
      out_idx++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL wrap_state[%0d] got=%h exp=%h", r, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, W'($urandom));
    cyc(1, 0, 1, 0, 16'hBEEF);
    checks++;
    if (bus.count !== CW'(0) || bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL flush count=%0d empty=%b ovf=%b exp 0/1/0", bus.count, bus.empty, bus.overflow);
    end
    cyc(1, 0, 0, 0, 16'h5A5A);
    cyc(0, 1, 0, 0, '0);
    checks++;
    if (obs_vec() !== exp_vec() || bus.data_out !== 16'h5A5A) begin
      failures++;
      $display("FAIL post_flush got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, W'($urandom));
    cyc(0, 1, 0, 0, '0);
    #3;
    reset_n = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=%h", obs_vec(), exp_vec());
    end
    #1;
    reset_n = 1'b0;
    cyc(1, 0, 0, 0, 16'h0F0F);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL after_mid_reset got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit p, po, f, ce;
    for (int i = 0; i < 400; i++) begin
      // Alternate push-heavy and pop-heavy phases to visit full and empty.
      p  = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      po = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 31) == 0);
      ce = ($urandom_range(0, 7) == 0);
      cyc(p, po, f, ce, W'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_underflow();
    test_full_push_pop();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous single-clock FIFO. It is the successor to the fixed 16x8 FIFO and is generalised in width and depth. It adds an occupancy count, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, a synchronous flush, and defined simultaneous push/pop behaviour. It is used as the general buffering primitive between producer and consumer blocks in the datapath.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of entries; must be a power of two and >=2
AFULL_THRESH, 6, almost_full asserts when count >= AFULL_THRESH (1..DEPTH)
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH (0..DEPTH-1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  reset, asynchronous, active-high
push  input  1  write request; data_in captured on the edge if accepted
pop  input  1  read request
flush  input  1  synchronous empty of FIFO contents
clear_err  input  1  synchronous clear of the overflow and underflow flags
data_in  input  WIDTH  write data
data_out  output  WIDTH  read data
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
overflow  output  1  sticky: a push was rejected
underflow  output  1  sticky: a pop was rejected

Behaviour:
- Reset (reset_n=1, asynchronous): pointers=0, count=0, data_out=0, overflow=0, underflow=0, empty=1, full=0, almost_full=0, almost_empty=1.
- Flags full, empty, almost_full and almost_empty are combinational decodes of registered count. They are glitch-free relative to clk.
- Accepted push: push=1 and (full=0 or an accepted pop occurs in the same cycle). The write goes to wr_ptr, and wr_ptr increments modulo DEPTH.
- Accepted pop: pop=1 and empty=0. rd_ptr increments modulo DEPTH.
- Read latency (default build): on an accepted pop, data_out is loaded at that edge with the entry at rd_ptr. It is valid from the following cycle and holds until the next accepted pop.
- count update per edge: +1 for push-only, -1 for pop-only, unchanged for both or neither.
- Simultaneous push+pop when full: both are accepted, count stays DEPTH, and the write lands in the slot being freed. There is no overflow.
- Simultaneous push+pop when empty: the pop is rejected (underflow=1), the push is accepted, count becomes 1, and data_out holds.
- Rejected push (full, no pop): memory and pointers are unchanged, and overflow is set at that edge.
- Rejected pop (empty): data_out and pointers are unchanged, and underflow is set.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no gap. Ordering is strictly first-in first-out across any number of wraps.
- flush=1 has priority over push and pop in the same cycle. It sets pointers=0 and count=0. data_out holds its value, memory contents are unchanged, and error flags are unchanged.
- clear_err=1 clears overflow and underflow. A new error event in the same cycle wins, so the flag stays 1.
- Reset asserted mid-operation returns all state to reset values immediately, regardless of clk.
- Memory array needs no reset.

Optional Feature:
- Macro FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined: data_out always presents the entry at rd_ptr whenever empty=0, with zero-cycle latency after the write edge. An accepted pop advances to the next entry. When empty=1, data_out holds the last presented word (0 after reset).
- Not defined: the registered pop-load read described above.
- All flag, count, flush and error behaviour is identical in both modes.

Test Plan:
- Reset, then 8 pushes of alternating 16'hFFFF/16'h0000 (defaults): count steps 1..8; almost_full rises at count=6; full=1 at 8; almost_empty falls at count=3.
- Ninth push of 16'hAAAA while full: overflow=1, count=8. Then 8 pops return FFFF,0000,... in order, 16'hAAAA never appears, and ending state is empty=1.
- Pop while empty: underflow=1 and data_out unchanged. clear_err then drops both flags. clear_err together with a rejected pop keeps underflow=1.
- Fill to 8, then push 16'h1234 + pop together: count stays 8 and there is no overflow. Draining returns the original 7 remaining words followed by 16'h1234.
- Wrap: 20 interleaved push/pop rounds starting at count 5 with data 0..N: every output equals its input index in order. Run in both default and FIFO_FWFT_EN builds, checking latency 1 versus 0.
- flush at count=5 with a push in the same cycle: count=0, empty=1, and the push is discarded. Separately, assert reset between clock edges mid-stream: outputs reach reset values before the next edge.
